writeback_arbiter: RTL and testbench

Write-back stage feeding the single write port of `registerFile`. It merges two result streams into one registered write per cycle: single-cycle integer/ALU results, and results from the multi-cycle floating-point unit. Integer results have priority and never wait, except under the starvation guard. FP results are buffered in a small FIFO behind a valid/ready handshake. The block also exposes a pending-write lookup so decode can detect RAW hazards on buffered FP results.

---
 rtl/mips_pkg.sv | 16 +
 rtl/wb_fifo.sv | 86 ++++++++
 rtl/writeback_arbiter.sv | 151 +++++++++++++++
 tb/tb_writeback_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared widths, constants and write-back select encoding for the MIPS datapath.
package mips_pkg;

    localparam int REG_ADDR_W = 6;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 6'd0;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_INT   = 2'd1,
        WB_FP    = 2'd2,
        WB_FORCE = 2'd3
    } wb_sel_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for FP write-back results.
// Per-entry reg/valid vectors are exposed so that decode can check for RAW hazards.
module wb_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push_i,
    input  logic [REG_ADDR_W-1:0]              push_reg_i,
    input  logic [DATA_W-1:0]                  push_data_i,
    input  logic                               pop_i,
    output logic [REG_ADDR_W-1:0]              head_reg_o,
    output logic [DATA_W-1:0]                  head_data_o,
    output logic [$clog2(DEPTH):0]             count_o,
    output logic                               empty_o,
    output logic                               full_o,
    output logic [DEPTH-1:0]                   entry_vld_o,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]   entry_reg_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                 count_q, count_d;
    logic [DEPTH-1:0]                 vld_q, vld_d;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] reg_q;
    logic [DEPTH-1:0][DATA_W-1:0]     data_q;
    logic                             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        vld_d    = vld_q;
        // Pop is applied before push so a same-cycle pair leaves occupancy unchanged.
        if (do_pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PTR_W'(1);
        end
        if (do_push) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
            reg_q    <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
            if (do_push) begin
                reg_q[wr_ptr_q]  <= push_reg_i;
                data_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

    assign head_reg_o  = reg_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign count_o     = count_q;
    assign entry_vld_o = vld_q;
    assign entry_reg_o = reg_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Merges integer and buffered FP results onto the single register-file write port.
// Integer has priority, except that a starvation guard periodically forces an FP drain.
module writeback_arbiter
    import mips_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    intValid,
    input  logic [REG_ADDR_W-1:0]   intReg,
    input  logic [DATA_W-1:0]       intData,
    input  logic                    intFloat,
    output logic                    intStall,
    input  logic                    fpValid,
    output logic                    fpReady,
    input  logic [REG_ADDR_W-1:0]   fpReg,
    input  logic [DATA_W-1:0]       fpData,
    output logic [REG_ADDR_W-1:0]   writeReg,
    output logic [DATA_W-1:0]       writeData,
    output logic                    regWrite,
    output logic                    float,
    input  logic [REG_ADDR_W-1:0]   lookupReg1,
    input  logic [REG_ADDR_W-1:0]   lookupReg2,
    output logic                    pendingHit1,
    output logic                    pendingHit2,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    wb_sel_t                          sel;
    logic                             push, pop;
    logic                             fifo_empty, fifo_full;
    logic [REG_ADDR_W-1:0]            head_reg;
    logic [DATA_W-1:0]                head_data;
    logic [DEPTH-1:0]                 entry_vld;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_reg;

    logic [STV_W-1:0]      starve_q, starve_d;
    logic                  stall_q, stall_d;
    logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  wen_q, wen_d;
    logic                  wfloat_q, wfloat_d;

    assign fpReady = !rst && !fifo_full;
    assign push    = fpValid && fpReady;
    assign pop     = (sel == WB_FP) || (sel == WB_FORCE);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_reg_i  (fpReg),
        .push_data_i (fpData),
        .pop_i       (pop),
        .head_reg_o  (head_reg),
        .head_data_o (head_data),
        .count_o     (count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .entry_vld_o (entry_vld),
        .entry_reg_o (entry_reg)
    );

    always_comb begin
        sel = WB_IDLE;
        if (stall_q) begin
            // The integer source is holding its result this cycle; it is ignored here.
            sel = fifo_empty ? WB_IDLE : WB_FORCE;
        end else if (intValid) begin
            sel = WB_INT;
        end else if (!fifo_empty) begin
            sel = WB_FP;
        end
    end

    always_comb begin
        starve_d = starve_q;
        stall_d  = 1'b0;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (sel == WB_INT) begin
            if (starve_q == STV_W'(STARVE_LIMIT - 1)) begin
                starve_d = '0;
                stall_d  = 1'b1;
            end else begin
                starve_d = starve_q + STV_W'(1);
            end
        end
    end

    always_comb begin
        wreg_d   = '0;
        wdata_d  = '0;
        wen_d    = 1'b0;
        wfloat_d = 1'b0;
        case (sel)
            WB_INT: begin
                wreg_d   = intReg;
                wdata_d  = intData;
                wfloat_d = intFloat;
                wen_d    = !((intReg == ZERO_REG) && !intFloat);
            end
            WB_FP, WB_FORCE: begin
                wreg_d   = head_reg;
                wdata_d  = head_data;
                wfloat_d = 1'b1;
                wen_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
            wen_q    <= 1'b0;
            wfloat_q <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
            wen_q    <= wen_d;
            wfloat_q <= wfloat_d;
        end
    end

    // A head entry being popped is still valid this cycle, so it keeps reporting a hit.
    always_comb begin
        pendingHit1 = 1'b0;
        pendingHit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i] && (entry_reg[i] == lookupReg1)) pendingHit1 = 1'b1;
            if (entry_vld[i] && (entry_reg[i] == lookupReg2)) pendingHit2 = 1'b1;
        end
    end

    assign intStall  = stall_q;
    assign writeReg  = wreg_q;
    assign writeData = wdata_q;
    assign regWrite  = wen_q;
    assign float     = wfloat_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: integer/FP merge, zero register, lookup,
// full FIFO, starvation drain and mid-drain reset.
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        intValid, intFloat, intStall;
    logic [5:0]  intReg;
    logic [31:0] intData;
    logic        fpValid, fpReady;
    logic [5:0]  fpReg;
    logic [31:0] fpData;
    logic [5:0]  writeReg;
    logic [31:0] writeData;
    logic        regWrite, float;
    logic [5:0]  lookupReg1, lookupReg2;
    logic        pendingHit1, pendingHit2;
    logic [2:0]  count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .intValid(intValid), .intReg(intReg), .intData(intData), .intFloat(intFloat),
        .intStall(intStall),
        .fpValid(fpValid), .fpReady(fpReady), .fpReg(fpReg), .fpData(fpData),
        .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite), .float(float),
        .lookupReg1(lookupReg1), .lookupReg2(lookupReg2),
        .pendingHit1(pendingHit1), .pendingHit2(pendingHit2),
        .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [5:0] r,
                          input logic [31:0] d, input logic f);
        chk({tag, ".regWrite"}, 32'(regWrite), 32'(en));
        chk({tag, ".writeReg"}, 32'(writeReg), 32'(r));
        chk({tag, ".writeData"}, writeData, d);
        chk({tag, ".float"}, 32'(float), 32'(f));
    endtask

    initial begin
        rst = 1'b1;
        intValid = 0; intReg = 0; intData = 0; intFloat = 0;
        fpValid = 0; fpReg = 0; fpData = 0;
        lookupReg1 = 0; lookupReg2 = 0;
        #1;
        chk_wr("reset", 1'b0, 6'd0, 32'd0, 1'b0);
        chk("reset.intStall", 32'(intStall), 32'd0);
        chk("reset.count", 32'(count), 32'd0);
        chk("reset.fpReady", 32'(fpReady), 32'd0);
        chk("reset.pendingHit1", 32'(pendingHit1), 32'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("post_reset.fpReady", 32'(fpReady), 32'd1);

        // integer write reg1 = 44
        intValid = 1; intReg = 6'd1; intData = 32'd44; intFloat = 0;
        tick();
        chk_wr("int_r1", 1'b1, 6'd1, 32'd44, 1'b0);

        // zero register suppressed for integer bank, writable for FP bank
        intReg = 6'd0; intData = 32'hDEADBEEF;
        tick();
        chk("int_r0.regWrite", 32'(regWrite), 32'd0);
        intFloat = 1;
        tick();
        chk_wr("int_r0_float", 1'b1, 6'd0, 32'hDEADBEEF, 1'b1);
        intValid = 0; intFloat = 0;
        tick();
        chk("idle.regWrite", 32'(regWrite), 32'd0);

        // two FP results with integer path idle
        fpValid = 1; fpReg = 6'd3; fpData = 32'h3F800000; lookupReg1 = 6'd3; lookupReg2 = 6'd4;
        #1;
        chk("lookup_not_on_push", 32'(pendingHit1), 32'd0);
        tick();
        chk("fp.count1", 32'(count), 32'd1);
        chk("fp.hit_r3_while_pop", 32'(pendingHit1), 32'd1);
        chk("fp.no_write_yet", 32'(regWrite), 32'd0);
        fpReg = 6'd4; fpData = 32'h40000000;
        tick();
        chk_wr("fp_r3", 1'b1, 6'd3, 32'h3F800000, 1'b1);
        chk("fp.count_push_pop", 32'(count), 32'd1);
        chk("fp.hit_r3_retired", 32'(pendingHit1), 32'd0);
        chk("fp.hit_r4", 32'(pendingHit2), 32'd1);
        fpValid = 0;
        tick();
        chk_wr("fp_r4", 1'b1, 6'd4, 32'h40000000, 1'b1);
        chk("fp.count0", 32'(count), 32'd0);
        tick();
        chk("fp.idle", 32'(regWrite), 32'd0);

        // fill FIFO while integer path is busy every cycle
        intValid = 1; intReg = 6'd5; intFloat = 0; fpValid = 1;
        for (int i = 0; i < 4; i++) begin
            fpReg = 6'(10 + i); fpData = 32'hF0000000 + 32'(10 + i);
            intData = 32'(100 + i);
            tick();
            chk("fill.int_data", writeData, 32'(100 + i));
            chk("fill.int_wr", 32'(regWrite), 32'd1);
        end
        fpValid = 0;
        chk("fill.count4", 32'(count), 32'd4);
        chk("fill.fpReady0", 32'(fpReady), 32'd0);

        // starvation: counter already at 3 after the fill
        for (int k = 0; k < 5; k++) begin
            intData = 32'(200 + k);
            tick();
            chk("starve1.int_data", writeData, 32'(200 + k));
            chk("starve1.intStall", 32'(intStall), 32'(k == 4));
        end
        tick();
        chk_wr("forced_fp10", 1'b1, 6'd10, 32'hF000000A, 1'b1);
        chk("forced.intStall_cleared", 32'(intStall), 32'd0);
        chk("forced.count3", 32'(count), 32'd3);
        tick();
        chk_wr("held_int", 1'b1, 6'd5, 32'd204, 1'b0);
        for (int j = 0; j < 7; j++) begin
            intData = 32'(300 + j);
            tick();
            chk("starve2.int_data", writeData, 32'(300 + j));
            chk("starve2.intStall", 32'(intStall), 32'(j == 6));
        end
        tick();
        chk_wr("forced_fp11", 1'b1, 6'd11, 32'hF000000B, 1'b1);
        chk("forced2.count2", 32'(count), 32'd2);
        fpValid = 1; fpReg = 6'd20; fpData = 32'hF0000014;
        tick();
        chk_wr("held_int2", 1'b1, 6'd5, 32'd306, 1'b0);
        chk("predrain.count3", 32'(count), 32'd3);
        fpValid = 0; intValid = 0; lookupReg1 = 6'd12;
        #1;
        chk("predrain.hit_r12", 32'(pendingHit1), 32'd1);

        // reset in the middle of the drain
        #2 rst = 1'b1;
        #1;
        chk_wr("midrst", 1'b0, 6'd0, 32'd0, 1'b0);
        chk("midrst.count", 32'(count), 32'd0);
        chk("midrst.fpReady", 32'(fpReady), 32'd0);
        chk("midrst.hit", 32'(pendingHit1), 32'd0);
        chk("midrst.intStall", 32'(intStall), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("after_rst.fpReady", 32'(fpReady), 32'd1);
        chk("after_rst.count", 32'(count), 32'd0);
        tick();
        chk("after_rst.no_stale1", 32'(regWrite), 32'd0);
        tick();
        chk("after_rst.no_stale2", 32'(regWrite), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
